// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: forward-mux capture into an output register with a one-entry skid buffer.
// Optional operand forwarding from MEM/WB is enabled by defining IDEX_FWD_EN.
module idex_operand_stage #(
   parameter int WIDTH = 64,
   parameter int OPW   = 4,
   parameter int RDW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OPW-1:0]   in_op,
   input  logic [RDW-1:0]   in_rd,
   input  logic [1:0]       fwd_a_sel,
   input  logic [1:0]       fwd_b_sel,
   input  logic [WIDTH-1:0] fwd_mem_data,
   input  logic [WIDTH-1:0] fwd_wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   output logic [RDW-1:0]   alu_rd
);

   logic             r_out_valid;
   logic             r_skid_valid;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [OPW-1:0]   r_alu_op;
   logic [RDW-1:0]   r_alu_rd;
   logic [WIDTH-1:0] r_skid_a;
   logic [WIDTH-1:0] r_skid_b;
   logic [OPW-1:0]   r_skid_op;
   logic [RDW-1:0]   r_skid_rd;

   logic             w_accept;
   logic             w_drain;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;

   function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] rf,
                                                input logic [WIDTH-1:0] mem,
                                                input logic [WIDTH-1:0] wb);
      logic [WIDTH-1:0] res;
      case (sel)
         2'b01:   res = mem;
         2'b10:   res = wb;
         default: res = rf;
      endcase
      return res;
   endfunction

   assign in_ready  = ~r_skid_valid;
   assign out_valid = r_out_valid;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign alu_rd    = r_alu_rd;

   assign w_accept = in_valid & ~r_skid_valid;
   assign w_drain  = r_out_valid & out_ready;

`ifdef IDEX_FWD_EN
   // Operand selection is resolved once, in the accepting cycle.
   always_comb begin
      w_a = fwd_mux(fwd_a_sel, in_a, fwd_mem_data, fwd_wb_data);
      w_b = fwd_mux(fwd_b_sel, in_b, fwd_mem_data, fwd_wb_data);
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{fwd_a_sel, fwd_b_sel, fwd_mem_data, fwd_wb_data};

   // Without forwarding the register-file operands pass straight through.
   always_comb begin
      w_a = in_a;
      w_b = in_b;
   end
`endif

   // OUT/SKID pipeline registers: reset, flush, then load-from-skid, load-from-input, or skid fill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_alu_rd     <= '0;
         r_skid_a     <= '0;
         r_skid_b     <= '0;
         r_skid_op    <= '0;
         r_skid_rd    <= '0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_out_valid || w_drain) begin
         if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_alu_a      <= r_skid_a;
            r_alu_b      <= r_skid_b;
            r_alu_op     <= r_skid_op;
            r_alu_rd     <= r_skid_rd;
            r_skid_valid <= w_accept;
            if (w_accept) begin
               r_skid_a  <= w_a;
               r_skid_b  <= w_b;
               r_skid_op <= in_op;
               r_skid_rd <= in_rd;
            end
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_alu_a     <= w_a;
            r_alu_b     <= w_b;
            r_alu_op    <= in_op;
            r_alu_rd    <= in_rd;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid_valid <= 1'b1;
         r_skid_a     <= w_a;
         r_skid_b     <= w_b;
         r_skid_op    <= in_op;
         r_skid_rd    <= in_rd;
      end
   end

endmodule
